spio_spinnaker_link_pkt_arbiter: RTL

//  Round-robin arbiter that merges packet streams from NUM_PORTS SpiNNaker link receivers

---
 rtl/spio_spinnaker_link_pkt_arbiter_pkg.sv | 31 +++
 rtl/spio_rr_priority_select.sv | 36 +++
 rtl/spio_spinnaker_link_pkt_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/spio_spinnaker_link_pkt_arbiter_pkg.sv
// rtl/spio_spinnaker_link_pkt_arbiter_pkg.sv - packet field layout, output state type and parity helper
// Shared by the link packet arbiter and its priority selector.
package spio_spinnaker_link_pkt_arbiter_pkg;

  localparam int PKT_BITS     = 72;
  localparam int PKT_HDR_LSB  = 0;
  localparam int PKT_HDR_W    = 8;
  localparam int PKT_KEY_LSB  = 8;
  localparam int PKT_KEY_W    = 32;
  localparam int PKT_PLD_LSB  = 40;
  localparam int PKT_PLD_W    = 32;
  localparam int PKT_PLD_BIT  = 1;
  localparam int PKT_PRTY_BIT = 0;
  localparam int DROP_CNT_W   = 16;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Odd parity over the whole packet when it carries a payload, else over hdr+key only.
  function automatic logic pkt_parity_ok(input logic [PKT_BITS-1:0] pkt);
    logic [PKT_PLD_LSB-1:0] short_bits;
    short_bits = pkt[PKT_PLD_LSB-1:0];
    if (pkt[PKT_PLD_BIT]) begin
      return ^pkt;
    end
    return ^short_bits;
  endfunction

endpackage

// File: rtl/spio_rr_priority_select.sv
// rtl/spio_rr_priority_select.sv - combinational round-robin requester selection
// Picks the first asserted request at or after ptr_i, wrapping modulo NUM_PORTS.
module spio_rr_priority_select #(
  parameter int NUM_PORTS = 4,
  parameter int PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [PTR_W-1:0]     ptr_i,
  output logic [NUM_PORTS-1:0] grant_oh_o,
  output logic [PTR_W-1:0]     grant_idx_o,
  output logic                 any_o
);

  always_comb begin
    int j;
    logic [PTR_W-1:0] idx;
    grant_oh_o  = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    j           = 0;
    idx         = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NUM_PORTS) begin
        j = j - NUM_PORTS;
      end
      idx = PTR_W'(j);
      if (!any_o && req_i[idx]) begin
        grant_oh_o[idx] = 1'b1;
        grant_idx_o     = idx;
        any_o           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spio_spinnaker_link_pkt_arbiter.sv
// rtl/spio_spinnaker_link_pkt_arbiter.sv - round-robin merge of link packet streams into one registered output
// Optional parity drop filter enabled by SPIO_ARB_PARITY_CHECK_EN.
module spio_spinnaker_link_pkt_arbiter
  import spio_spinnaker_link_pkt_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 4
) (
  input  logic                          CLK_IN,
  input  logic                          RESET_IN,
  input  logic [NUM_PORTS*PKT_BITS-1:0] PKT_DATA_IN,
  input  logic [NUM_PORTS-1:0]          PKT_VLD_IN,
  output logic [NUM_PORTS-1:0]          PKT_RDY_OUT,
  output logic [PKT_BITS-1:0]           PKT_DATA_OUT,
  output logic                          PKT_VLD_OUT,
  input  logic                          PKT_RDY_IN,
  output logic [DROP_CNT_W-1:0]         DROP_CNT_OUT
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  out_state_e           state_q, state_d;
  logic [PKT_BITS-1:0]  data_q, data_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;

  logic [NUM_PORTS-1:0] grant_oh;
  logic [PTR_W-1:0]     grant_idx;
  logic                 grant_any;
  logic                 free;
  logic                 accept;
  logic                 pkt_good;
  logic                 load;
  logic [PKT_BITS-1:0]  pkt_sel;

  spio_rr_priority_select #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_rr_select (
    .req_i       (PKT_VLD_IN),
    .ptr_i       (ptr_q),
    .grant_oh_o  (grant_oh),
    .grant_idx_o (grant_idx),
    .any_o       (grant_any)
  );

  // Buffer can take a packet when empty or when its current packet leaves this cycle.
  assign free        = (state_q == OUT_EMPTY) || PKT_RDY_IN;
  assign accept      = grant_any && free && !RESET_IN;
  assign PKT_RDY_OUT = RESET_IN ? '0 : (grant_oh & {NUM_PORTS{free}});

  always_comb begin
    pkt_sel = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      pkt_sel = pkt_sel | (PKT_DATA_IN[i*PKT_BITS +: PKT_BITS] & {PKT_BITS{grant_oh[i]}});
    end
  end

`ifdef SPIO_ARB_PARITY_CHECK_EN
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  assign pkt_good     = pkt_parity_ok(pkt_sel);
  assign DROP_CNT_OUT = drop_q;

  always_comb begin
    drop_d = drop_q;
    if (accept && !pkt_good && (drop_q != {DROP_CNT_W{1'b1}})) begin
      drop_d = drop_q + 1'b1;
    end
  end
`else
  assign pkt_good     = 1'b1;
  assign DROP_CNT_OUT = '0;
`endif

  // A rejected packet still completes its handshake, so only loading is gated by parity.
  assign load = accept && pkt_good;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    if (load) begin
      state_d = OUT_FULL;
      data_d  = pkt_sel;
    end else if ((state_q == OUT_FULL) && PKT_RDY_IN) begin
      state_d = OUT_EMPTY;
    end
    if (accept) begin
      ptr_d = (grant_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      state_q <= OUT_EMPTY;
      data_q  <= '0;
      ptr_q   <= '0;
`ifdef SPIO_ARB_PARITY_CHECK_EN
      drop_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
`ifdef SPIO_ARB_PARITY_CHECK_EN
      drop_q  <= drop_d;
`endif
    end
  end

  assign PKT_VLD_OUT  = (state_q == OUT_FULL);
  assign PKT_DATA_OUT = data_q;

endmodule
